// File: rtl/regfile_wr_arbiter.sv
// Round-robin share of the register-file write port between two requesters, plus an r1..r31 clear walk.
// Write lands on RegWrite/regW/Wdat the cycle after the handshake; readies drop to 0 while clearing.
module regfile_wr_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter bit CLR_ON_RST = 1'b0
) (
    input  logic          btn,
    input  logic          rst,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_reg,
    input  logic [DW-1:0] a_dat,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_reg,
    input  logic [DW-1:0] b_dat,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_done,
    output logic          RegWrite,
    output logic [AW-1:0] regW,
    output logic [DW-1:0] Wdat
);

    typedef enum logic {ARB, CLEAR} state_t;

    localparam state_t        RST_STATE = CLR_ON_RST ? CLEAR : ARB;
    localparam logic [AW-1:0] CNT_FIRST = AW'(1);
    localparam logic [AW-1:0] CNT_LAST  = {AW{1'b1}};
    localparam logic          PTR_A     = 1'b0;
    localparam logic          PTR_B     = 1'b1;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          regwrite_q, regwrite_d;
    logic [AW-1:0] regw_q, regw_d;
    logic [DW-1:0] wdat_q, wdat_d;
    logic          clr_done_q, clr_done_d;
    logic          grant_a, grant_b;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        regwrite_d = 1'b0;
        regw_d     = regw_q;
        wdat_d     = wdat_q;
        clr_done_d = 1'b0;
        grant_a    = 1'b0;
        grant_b    = 1'b0;

        case (state_q)
            ARB: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = CNT_FIRST;
                end else begin
                    grant_a = a_valid && (!b_valid || ptr_q == PTR_A);
                    grant_b = b_valid && !grant_a;
                    if (grant_a) begin
                        ptr_d      = PTR_B;
                        regwrite_d = (a_reg != '0);
                        regw_d     = a_reg;
                        wdat_d     = a_dat;
                    end else if (grant_b) begin
                        ptr_d      = PTR_A;
                        regwrite_d = (b_reg != '0);
                        regw_d     = b_reg;
                        wdat_d     = b_dat;
                    end
                end
            end
            CLEAR: begin
                regwrite_d = 1'b1;
                regw_d     = cnt_q;
                wdat_d     = '0;
                if (cnt_q == CNT_LAST) begin
                    // Reload to 1 on exit so cnt never passes through r0.
                    state_d    = ARB;
                    clr_done_d = 1'b1;
                    cnt_d      = CNT_FIRST;
                end else begin
                    cnt_d = cnt_q + CNT_FIRST;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge btn or negedge rst) begin
        if (!rst) begin
            state_q    <= RST_STATE;
            ptr_q      <= PTR_A;
            cnt_q      <= CNT_FIRST;
            regwrite_q <= 1'b0;
            regw_q     <= '0;
            wdat_q     <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            regwrite_q <= regwrite_d;
            regw_q     <= regw_d;
            wdat_q     <= wdat_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign busy     = (state_q == CLEAR);
    assign clr_done = clr_done_q;
    assign RegWrite = regwrite_q;
    assign regW     = regw_q;
    assign Wdat     = wdat_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: reference model feeds expected handshakes and writes into queues,
// monitors pop and compare them each cycle; a second instance covers clear-on-reset.
module tb_regfile_wr_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, b_valid, clr_req;
    logic [AW-1:0] a_reg, b_reg;
    logic [DW-1:0] a_dat, b_dat;
    logic          a_ready, b_ready, busy, clr_done, RegWrite;
    logic [AW-1:0] regW;
    logic [DW-1:0] Wdat;
    logic          u2_a_ready, u2_b_ready, u2_busy, u2_clr_done, u2_RegWrite;
    logic [AW-1:0] u2_regW;
    logic [DW-1:0] u2_Wdat;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.DW(DW), .AW(AW), .CLR_ON_RST(1'b0)) dut (
        .btn(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_dat(a_dat),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_dat(b_dat),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done),
        .RegWrite(RegWrite), .regW(regW), .Wdat(Wdat)
    );

    regfile_wr_arbiter #(.DW(DW), .AW(AW), .CLR_ON_RST(1'b1)) dut_cor (
        .btn(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(u2_a_ready), .a_reg(a_reg), .a_dat(a_dat),
        .b_valid(b_valid), .b_ready(u2_b_ready), .b_reg(b_reg), .b_dat(b_dat),
        .clr_req(clr_req), .busy(u2_busy), .clr_done(u2_clr_done),
        .RegWrite(u2_RegWrite), .regW(u2_regW), .Wdat(u2_Wdat)
    );

    typedef struct packed {
        logic rdy_a;
        logic rdy_b;
        logic busy;
    } rexp_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] r;
        logic [DW-1:0] d;
        logic          done;
    } oexp_t;

    rexp_t rq[$];
    oexp_t oq[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model state
    logic          m_clear;
    logic          m_ptr;
    logic [AW-1:0] m_cnt;
    logic          m_ga, m_gb;

    task automatic model_reset();
        m_clear = 1'b0;
        m_ptr   = 1'b0;
        m_cnt   = 5'd1;
        m_ga    = 1'b0;
        m_gb    = 1'b0;
    endtask

    // Applies one cycle of stimulus, queues the expected results, returns 3 time units after the edge.
    task automatic drive(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                         input logic bv, input logic [AW-1:0] br, input logic [DW-1:0] bd,
                         input logic clr);
        rexp_t re;
        oexp_t oe;
        a_valid = av; a_reg = ar; a_dat = ad;
        b_valid = bv; b_reg = br; b_dat = bd;
        clr_req = clr;
        re = '0;
        oe = '0;
        re.busy = m_clear;
        m_ga = 1'b0;
        m_gb = 1'b0;
        if (m_clear) begin
            oe.we   = 1'b1;
            oe.r    = m_cnt;
            oe.d    = '0;
            oe.done = (m_cnt == 5'd31);
            if (m_cnt == 5'd31) begin
                m_clear = 1'b0;
                m_cnt   = 5'd1;
            end else begin
                m_cnt = m_cnt + 5'd1;
            end
        end else if (clr) begin
            m_clear = 1'b1;
            m_cnt   = 5'd1;
        end else begin
            m_ga = av && (!bv || !m_ptr);
            m_gb = bv && !m_ga;
            if (m_ga) begin
                re.rdy_a = 1'b1;
                oe.we = (ar != 0); oe.r = ar; oe.d = ad;
                m_ptr = 1'b1;
            end else if (m_gb) begin
                re.rdy_b = 1'b1;
                oe.we = (br != 0); oe.r = br; oe.d = bd;
                m_ptr = 1'b0;
            end
        end
        rq.push_back(re);
        oq.push_back(oe);
        @(posedge clk);
        #3;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    always @(negedge clk) begin : mon_rdy
        rexp_t e;
        if (rq.size() != 0) begin
            e = rq.pop_front();
            checks++;
            if ({a_ready, b_ready, busy} !== {e.rdy_a, e.rdy_b, e.busy}) begin
                errors++;
                $display("FAIL handshake @%0t: a_ready,b_ready,busy got %b%b%b expected %b%b%b",
                         $time, a_ready, b_ready, busy, e.rdy_a, e.rdy_b, e.busy);
            end
        end
    end

    always @(posedge clk) begin : mon_out
        oexp_t e;
        #1;
        if (oq.size() != 0) begin
            e = oq.pop_front();
            checks++;
            if (RegWrite !== e.we || clr_done !== e.done ||
                (e.we && (regW !== e.r || Wdat !== e.d))) begin
                errors++;
                $display("FAIL write_port @%0t: got we=%b reg=%0d dat=%h done=%b expected we=%b reg=%0d dat=%h done=%b",
                         $time, RegWrite, regW, Wdat, clr_done, e.we, e.r, e.d, e.done);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        a_valid = 0; b_valid = 0; clr_req = 0;
        a_reg = 0; b_reg = 0; a_dat = 0; b_dat = 0;
        #12;
        checks++;
        if ({RegWrite, regW, Wdat, clr_done, busy, a_ready, b_ready} !== '0) begin
            errors++;
            $display("FAIL reset_values: we=%b reg=%0d dat=%h done=%b busy=%b rdy=%b%b, required all 0",
                     RegWrite, regW, Wdat, clr_done, busy, a_ready, b_ready);
        end
        @(negedge clk) rst = 1'b1;
        model_reset();
        @(posedge clk); #3;
        drive(1'b1, 5'd4, 32'h11, 1'b0, 5'd0, 32'h0, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h22, 1'b0);
        drive(1'b1, 5'd12, 32'h33, 1'b1, 5'd13, 32'h44, 1'b0);
        // Mid-traffic reset: a write is currently on the port
        a_valid = 0; b_valid = 0;
        rst = 1'b0;
        #1;
        checks++;
        if ({RegWrite, regW, Wdat, busy, a_ready, b_ready} !== '0) begin
            errors++;
            $display("FAIL reset_mid_traffic: we=%b reg=%0d dat=%h busy=%b rdy=%b%b, required all 0",
                     RegWrite, regW, Wdat, busy, a_ready, b_ready);
        end
        model_reset();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #3;
        drive(1'b1, 5'd1, 32'h55, 1'b1, 5'd2, 32'h66, 1'b0);
        checks++;
        if (regW !== 5'd1) begin
            errors++;
            $display("FAIL reset_first_grant: regW=%0d, required 1 (requester A)", regW);
        end
        idle();
    endtask

    task automatic test_r0_drop();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hBAD, 1'b0);
        checks++;
        if (RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL r0_drop: RegWrite=%b, required 0", RegWrite);
        end
        idle();
    endtask

    task automatic test_contention();
        logic [AW-1:0] seen [4];
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, 32'hA3A3, 1'b1, 5'd7, 32'hB7B7, 1'b0);
            seen[i] = regW;
        end
        checks++;
        if (seen[0] !== 5'd3 || seen[1] !== 5'd7 || seen[2] !== 5'd3 || seen[3] !== 5'd7) begin
            errors++;
            $display("FAIL contention_order: regW %0d,%0d,%0d,%0d, required 3,7,3,7",
                     seen[0], seen[1], seen[2], seen[3]);
        end
        idle();
    endtask

    task automatic test_single();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++;
        if (RegWrite !== 1'b1 || regW !== 5'd5 || Wdat !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_write: we=%b reg=%0d dat=%h, required 1/5/deadbeef", RegWrite, regW, Wdat);
        end
        idle();
        checks++;
        if (RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: RegWrite=%b one cycle later, required 0", RegWrite);
        end
    endtask

    task automatic test_clear();
        drive(1'b1, 5'd8, 32'hCAFE, 1'b0, 5'd0, 32'h0, 1'b1);
        for (int i = 0; i < 31; i++)
            drive(1'b1, 5'd8, 32'hCAFE, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++;
        if (clr_done !== 1'b1 || regW !== 5'd31 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_end: done=%b reg=%0d busy=%b, required 1/31/0", clr_done, regW, busy);
        end
        drive(1'b1, 5'd8, 32'hCAFE, 1'b0, 5'd0, 32'h0, 1'b0);
        idle();
    endtask

    task automatic test_back_to_back();
        logic          av, bv, clr;
        logic [AW-1:0] ar, br;
        logic [DW-1:0] ad, bd;
        av = 0; bv = 0; ar = 0; br = 0; ad = 0; bd = 0;
        for (int n = 0; n < 300; n++) begin
            if (!av || m_ga) begin
                av = 1'($urandom_range(0, 1)); ar = 5'($urandom_range(0, 31)); ad = $urandom;
            end
            if (!bv || m_gb) begin
                bv = 1'($urandom_range(0, 1)); br = 5'($urandom_range(0, 31)); bd = $urandom;
            end
            clr = !m_clear && ($urandom_range(0, 39) == 0);
            drive(av, ar, ad, bv, br, bd, clr);
        end
        while (m_clear) idle();
        idle();
    endtask

    task automatic test_abort();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) idle();
        checks++;
        if (regW !== 5'd10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: regW=%0d busy=%b, required 10/1", regW, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({RegWrite, regW, Wdat, busy, clr_done} !== '0) begin
            errors++;
            $display("FAIL abort_idle: we=%b reg=%0d dat=%h busy=%b done=%b, required all 0",
                     RegWrite, regW, Wdat, busy, clr_done);
        end
        model_reset();
        @(negedge clk) rst = 1'b1;
        fork
            begin
                @(posedge clk); #3;
                for (int i = 0; i < 34; i++) idle();
            end
            begin
                for (int i = 1; i <= 31; i++) begin
                    @(posedge clk); #2;
                    checks++;
                    if (u2_RegWrite !== 1'b1 || u2_regW !== i[AW-1:0] || u2_Wdat !== '0 ||
                        u2_clr_done !== (i == 31) || u2_busy !== (i < 31) ||
                        u2_a_ready !== 1'b0 || u2_b_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL clr_on_rst step %0d: we=%b reg=%0d dat=%h done=%b busy=%b rdy=%b%b",
                                 i, u2_RegWrite, u2_regW, u2_Wdat, u2_clr_done, u2_busy,
                                 u2_a_ready, u2_b_ready);
                    end
                end
            end
        join
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_r0_drop();
        test_contention();
        test_single();
        test_clear();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
